// File: rtl/decode_branch_control.sv
// -----------------------------------------------------------------------------
// decode_branch_control
//
// Instruction-decode control slice of the pipelined MIPS core. Decodes the
// IF/ID opcode into the main datapath control signals, computes the branch and
// jump targets from the IF/ID PC+4 value, and registers the execute-bound
// control bundle and sign-extended immediate into the ID/EX stage.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr, pc         instruction and PC+4 from IF/ID
//   rs_eq_rt          branch comparator result
//   hold, flush       ID/EX stall and bubble insertion (flush wins)
//   reg_dst .. reg_write, alu_op
//                     combinational decode of instr[31:26]
//   branch_taken      branch & rs_eq_rt
//   branch_target     pc + (sext(imm) << 2), wraps modulo 2^32
//   jump_target       {pc[31:28], instr[25:0], 2'b00}
//   ctrl_q            registered {RegDst, MemRead, MemtoReg, ALUOp, MemWrite,
//                     ALUSrc, RegWrite}
//   imm_q             registered sign-extended immediate
// -----------------------------------------------------------------------------
module decode_branch_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        rs_eq_rt,
  input  logic        hold,
  input  logic        flush,
  output logic        reg_dst,
  output logic        jump,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [7:0]  ctrl_q,
  output logic [31:0] imm_q
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  logic [31:0] imm_sext;
  logic [7:0]  ctrl_dec;
  logic [7:0]  ctrl_d;
  logic [31:0] imm_d;

  // NOTE: every signal written here gets a default first, so opcodes outside
  // the decoded set fall through to an all-zero NOP and no latch is inferred.
  always_comb begin
    reg_dst    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (instr[31:26])
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LW: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_dec = {reg_dst, mem_read, mem_to_reg, alu_op, mem_write,
                     alu_src, reg_write};

  assign imm_sext      = {{16{instr[15]}}, instr[15:0]};
  // Shifting left by two drops the top two bits of the extended immediate.
  assign branch_target = pc + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc[31:28], instr[25:0], 2'b00};
  assign branch_taken  = branch & rs_eq_rt;

  // A bubble clears the control bundle, but the immediate only advances when
  // the stage is not also stalled.
  always_comb begin
    ctrl_d = ctrl_q;
    imm_d  = imm_q;
    if (flush) begin
      ctrl_d = 8'h00;
      if (!hold) imm_d = imm_sext;
    end else if (!hold) begin
      ctrl_d = ctrl_dec;
      imm_d  = imm_sext;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 8'h00;
      imm_q  <= 32'h0000_0000;
    end else begin
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
    end
  end

endmodule

// File: tb/tb_decode_branch_control.sv
// -----------------------------------------------------------------------------
// tb_decode_branch_control
//
// Self-checking bench: a table of directed vectors, hand-written stall/flush
// and reset sequences, then random stimulus compared against a behavioural
// model of the decode table, target arithmetic and ID/EX update rules.
// -----------------------------------------------------------------------------
module tb_decode_branch_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc;
  logic        rs_eq_rt, hold, flush;
  logic        reg_dst, jump, branch, mem_read, mem_to_reg, mem_write;
  logic        alu_src, reg_write, branch_taken;
  logic [1:0]  alu_op;
  logic [31:0] branch_target, jump_target, imm_q;
  logic [7:0]  ctrl_q;

  always #5 clk = ~clk;

  decode_branch_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .pc            (pc),
    .rs_eq_rt      (rs_eq_rt),
    .hold          (hold),
    .flush         (flush),
    .reg_dst       (reg_dst),
    .jump          (jump),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .ctrl_q        (ctrl_q),
    .imm_q         (imm_q)
  );

  int errors = 0;
  int checks = 0;

  // Reference state of the ID/EX fields.
  logic [7:0]  m_ctrl;
  logic [31:0] m_imm;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rs_eq_rt;
    logic [7:0]  ctrl;
    logic        jump;
    logic        branch;
    logic        taken;
    logic [31:0] btarget;
    logic [31:0] jtarget;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Decode table: returns {jump, branch, ctrl[7:0]}.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return {2'b00, 8'h91};
      6'b100011: return {2'b00, 8'h63};
      6'b101011: return {2'b00, 8'h06};
      6'b000100: return {2'b01, 8'h08};
      6'b001000: return {2'b00, 8'h03};
      6'b000010: return {2'b10, 8'h00};
      default:   return 10'h000;
    endcase
  endfunction

  function automatic logic [31:0] ref_sext(input logic [31:0] ins);
    int s;
    s = int'($signed(ins[15:0]));
    return 32'(s);
  endfunction

  function automatic logic [7:0] dut_ctrl();
    return {reg_dst, mem_read, mem_to_reg, alu_op, mem_write, alu_src,
            reg_write};
  endfunction

  task automatic check_comb_model(input string tag);
    logic [9:0]  d;
    logic [31:0] bt, jt;
    d  = ref_decode(instr[31:26]);
    bt = pc + ref_sext(instr) * 32'd4;
    jt = (pc & 32'hF000_0000) | (32'(instr[25:0]) * 32'd4);
    check({tag, ".ctrl"},   32'(dut_ctrl()),     32'(d[7:0]));
    check({tag, ".jump"},   32'(jump),           32'(d[9]));
    check({tag, ".branch"}, 32'(branch),         32'(d[8]));
    check({tag, ".taken"},  32'(branch_taken),   32'(d[8] & rs_eq_rt));
    check({tag, ".btgt"},   branch_target,       bt);
    check({tag, ".jtgt"},   jump_target,         jt);
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic clock_edge(input string tag);
    logic [7:0]  n_ctrl;
    logic [31:0] n_imm;
    logic [9:0]  d;
    d      = ref_decode(instr[31:26]);
    n_ctrl = m_ctrl;
    n_imm  = m_imm;
    if (flush) begin
      n_ctrl = 8'h00;
      if (!hold) n_imm = ref_sext(instr);
    end else if (!hold) begin
      n_ctrl = d[7:0];
      n_imm  = ref_sext(instr);
    end
    @(posedge clk);
    #1;
    m_ctrl = n_ctrl;
    m_imm  = n_imm;
    check({tag, ".ctrl_q"}, 32'(ctrl_q), 32'(m_ctrl));
    check({tag, ".imm_q"},  imm_q,       m_imm);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic eq, input logic h, input logic f);
    instr    = i;
    pc       = p;
    rs_eq_rt = eq;
    hold     = h;
    flush    = f;
    #1;
  endtask

  initial begin
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b000010, 6'b111111};

    vecs.push_back('{32'h0000_0000, 32'h0040_0000, 1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'h8C00_0000, 32'h0040_0000, 1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'hAC00_0000, 32'h0040_0000, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'h1000_0000, 32'h0040_0000, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'h2000_0000, 32'h0040_0000, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'h0800_0000, 32'h0040_0000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'hFC00_0000, 32'h0040_0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000});
    vecs.push_back('{32'h1000_FFFF, 32'h0000_0100, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h0000_00FC, 32'h0003_FFFC});
    vecs.push_back('{32'h1000_FFFF, 32'h0000_0100, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 32'h0000_00FC, 32'h0003_FFFC});
    vecs.push_back('{32'h1000_0001, 32'hFFFF_FFFC, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hF000_0004});
    vecs.push_back('{32'h0800_0010, 32'h1000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h1000_0040, 32'h1000_0040});

    // Reset state.
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    m_ctrl = 8'h00;
    m_imm  = 32'h0;
    check("reset.ctrl_q", 32'(ctrl_q), 32'h00);
    check("reset.imm_q",  imm_q,       32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: combinational outputs, then the registered bundle.
    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rs_eq_rt, 1'b0, 1'b0);
      check($sformatf("vec%0d.ctrl", k),   32'(dut_ctrl()),    32'(vecs[k].ctrl));
      check($sformatf("vec%0d.jump", k),   32'(jump),          32'(vecs[k].jump));
      check($sformatf("vec%0d.branch", k), 32'(branch),        32'(vecs[k].branch));
      check($sformatf("vec%0d.taken", k),  32'(branch_taken),  32'(vecs[k].taken));
      check($sformatf("vec%0d.btgt", k),   branch_target,      vecs[k].btarget);
      check($sformatf("vec%0d.jtgt", k),   jump_target,        vecs[k].jtarget);
      clock_edge($sformatf("vec%0d", k));
      check($sformatf("vec%0d.ctrl_q_tbl", k), 32'(ctrl_q), 32'(vecs[k].ctrl));
    end

    // Stall then bubble.
    drive(32'h8C22_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    clock_edge("lw");
    check("lw.ctrl_q_c", 32'(ctrl_q), 32'h63);
    check("lw.imm_q_c",  imm_q,       32'h4);
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
    clock_edge("hold");
    check("hold.ctrl_q_c", 32'(ctrl_q), 32'h63);
    check("hold.imm_q_c",  imm_q,       32'h4);
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
    clock_edge("flush");
    check("flush.ctrl_q_c", 32'(ctrl_q), 32'h00);
    check("flush.imm_q_c",  imm_q,       32'h0);

    // flush and hold together: bubble enters, immediate kept.
    drive(32'h8C22_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    clock_edge("lw2");
    drive(32'h2000_FFF0, 32'h0, 1'b0, 1'b1, 1'b1);
    clock_edge("flush_hold");
    check("flush_hold.ctrl_q_c", 32'(ctrl_q), 32'h00);
    check("flush_hold.imm_q_c",  imm_q,       32'h4);

    // Async reset between edges.
    drive(32'h0000_0020, 32'h0, 1'b0, 1'b0, 1'b0);
    clock_edge("rtype");
    check("rtype.ctrl_q_c", 32'(ctrl_q), 32'h91);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_ctrl = 8'h00;
    m_imm  = 32'h0;
    check("areset.ctrl_q",  32'(ctrl_q),  32'h00);
    check("areset.imm_q",   imm_q,        32'h0);
    check("areset.reg_dst", 32'(reg_dst), 32'h1);
    #1;
    rst_n = 1'b1;
    clock_edge("post_reset");
    check("post_reset.ctrl_q_c", 32'(ctrl_q), 32'h91);
    check("post_reset.imm_q_c",  imm_q,       32'h20);

    // Reset during a stall: stays clear until an unstalled edge.
    drive(32'h8C22_0004, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_ctrl = 8'h00;
    m_imm  = 32'h0;
    check("stall_reset.ctrl_q", 32'(ctrl_q), 32'h00);
    #1;
    rst_n = 1'b1;
    clock_edge("stall_reset_hold");
    check("stall_reset_hold.ctrl_q_c", 32'(ctrl_q), 32'h00);
    drive(32'h8C22_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    clock_edge("stall_reset_go");
    check("stall_reset_go.ctrl_q_c", 32'(ctrl_q), 32'h63);

    // Random stimulus against the model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      if ($urandom_range(0, 3) != 0) ri[31:26] = ops[$urandom_range(0, 6)];
      drive(ri, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      check_comb_model($sformatf("rnd%0d", n));
      clock_edge($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
